uart_tx_arbiter: RTL and testbench

Shares one UART transmit line among `NUM_REQ` byte-stream requesters using round-robin arbitration. It serializes the granted byte as an 8N1-style frame, timed by the bit-rate `baud_tick` pulse from `baudrate_generator`. It also owns the baud selection fed to that generator, and applies a new selection only between frames so no frame is ever sent at mixed rates.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, baud-select encodings and helpers for the
//               shared UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam logic [2:0] BAUD_SEL_9600   = 3'b001;
    localparam logic [2:0] BAUD_SEL_57600  = 3'b010;
    localparam logic [2:0] BAUD_SEL_115200 = 3'b100;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == BAUD_SEL_9600) || (v == BAUD_SEL_57600) || (v == BAUD_SEL_115200);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; searches upward from
//               last_grant+1 and wraps modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one 8N1-style UART transmit line among
//               NUM_REQ byte requesters, with between-frame baud selection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        baud_tick,
    input  logic [2:0]                  baud_sel_in,
    output logic [2:0]                  baud_sel_out,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W + 1);

    uart_state_e       state_q,    state_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [2:0]        baud_sel_q, baud_sel_d;
    logic              tx_q,       tx_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (grant_id_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        grant_id_d = grant_id_q;
        baud_sel_d = baud_sel_q;
        tx_d       = tx_q;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (is_onehot3(baud_sel_in)) begin
                    baud_sel_d = baud_sel_in;
                end
                // Ticks in the grant cycle are ignored: ALIGN only looks at later ones.
                if (|req_valid && !reset) begin
                    req_ready  = arb_grant;
                    shreg_d    = sel_data;
                    grant_id_d = arb_idx;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ALIGN;
                end
            end
            ALIGN: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            grant_id_q <= IDX_W'(NUM_REQ - 1);
            baud_sel_q <= BAUD_SEL_9600;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            grant_id_q <= grant_id_d;
            baud_sel_q <= baud_sel_d;
            tx_q       <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_id_q;
    assign baud_sel_out = baud_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (3-requester 8N1 and
//               2-requester 8N2 instances, baud tick every 16 clocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] tcnt = 4'd0;
    logic       baud_tick;
    logic [2:0] bsel_in;

    logic [2:0]  req_valid_a, req_ready_a, bsel_out_a;
    logic [23:0] req_data_a;
    logic        tx_a, busy_a;
    logic [1:0]  gid_a;

    logic [1:0]  req_valid_b, req_ready_b;
    logic [15:0] req_data_b;
    logic [2:0]  bsel_out_b;
    logic        tx_b, busy_b, gid_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] rq0[$], rq1[$], rq2[$];
    logic [7:0] exp_byte_q[$];
    int         exp_gid_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) tcnt <= tcnt + 4'd1;
    assign baud_tick = (tcnt == 4'd15);

    uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .STOP_BITS(1)) dut_a (
        .clock(clock), .reset(reset), .req_valid(req_valid_a), .req_data(req_data_a),
        .req_ready(req_ready_a), .baud_tick(baud_tick), .baud_sel_in(bsel_in),
        .baud_sel_out(bsel_out_a), .tx(tx_a), .busy(busy_a), .grant_id(gid_a)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .STOP_BITS(2)) dut_b (
        .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .baud_tick(baud_tick), .baud_sel_in(bsel_in),
        .baud_sel_out(bsel_out_b), .tx(tx_b), .busy(busy_b), .grant_id(gid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester model: present queued bytes, drop valid after the accepting edge.
    initial begin : driver
        int pk;
        bit pend;
        pk = 0; pend = 1'b0;
        req_valid_a = '0;
        req_data_a  = '0;
        forever begin
            @(negedge clock);
            if (pend) begin
                req_valid_a[pk] = 1'b0;
                pend = 1'b0;
            end
            if (!req_valid_a[0] && rq0.size() > 0) begin req_data_a[7:0]   = rq0.pop_front(); req_valid_a[0] = 1'b1; end
            if (!req_valid_a[1] && rq1.size() > 0) begin req_data_a[15:8]  = rq1.pop_front(); req_valid_a[1] = 1'b1; end
            if (!req_valid_a[2] && rq2.size() > 0) begin req_data_a[23:16] = rq2.pop_front(); req_valid_a[2] = 1'b1; end
            #1;
            if (!reset && |(req_ready_a & req_valid_a)) begin
                for (int k = 0; k < 3; k++) if (req_ready_a[k]) pk = k;
                pend = 1'b1;
            end
        end
    end

    initial begin : grant_mon
        int         g;
        logic [2:0] exp_rdy;
        forever begin
            @(negedge clock); #2;
            if (req_ready_a !== 3'b000) begin
                g = (exp_gid_q.size() > 0) ? exp_gid_q.pop_front() : 7;
                exp_rdy = '0;
                if (g < 3) exp_rdy[g] = 1'b1;
                chk("ready_onehot", req_ready_a, exp_rdy);
                @(negedge clock); #2;
                chk("ready_pulse_width", req_ready_a, 3'b000);
                chk("grant_id", gid_a, g[1:0]);
            end
        end
    end

    initial begin : frame_mon
        logic [9:0] bits;
        logic [8:0] expv;
        bit         bad, abort;
        forever begin
            @(negedge clock);
            if (!reset && busy_a && tx_a === 1'b0) begin
                bad = 1'b0; abort = 1'b0; bits = '0;
                for (int s = 0; s < 10 && !abort; s++) begin
                    if (s > 0) begin
                        @(negedge clock);
                        if (reset) abort = 1'b1;
                    end
                    bits[s] = tx_a;
                    for (int c = 1; c < 16 && !abort; c++) begin
                        @(negedge clock);
                        if (reset) abort = 1'b1;
                        else if (tx_a !== bits[s]) bad = 1'b1;
                    end
                end
                if (!abort) begin
                    chk("frame_start_stop", {bits[9], bits[0]}, 2'b10);
                    chk("frame_bit_width", bad, 1'b0);
                    expv = (exp_byte_q.size() > 0) ? {1'b1, exp_byte_q.pop_front()} : 9'h000;
                    chk("frame_byte", {1'b1, bits[8:1]}, expv);
                    @(negedge clock);
                    chk("busy_after_stop", busy_a, 1'b0);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(rq0.size() == 0 && rq1.size() == 0 && rq2.size() == 0 &&
               req_valid_a == 3'b000 && exp_byte_q.size() == 0 && !busy_a)) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle_in_budget", n < budget, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : main
        int n, c, hi;
        reset = 1'b1;
        bsel_in = 3'b001;
        req_valid_b = '0;
        req_data_b  = '0;
        repeat (3) @(negedge clock);
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_ready", req_ready_a, 3'b000);
        chk("rst_grant_id", gid_a, 2'd2);
        chk("rst_baud_sel", bsel_out_a, 3'b001);
        chk("rst_grant_id_b", gid_b, 1'b1);
        reset = 1'b0;

        // Single byte 0xA5 from requester 0.
        @(negedge clock); #3;
        rq0.push_back(8'hA5); exp_byte_q.push_back(8'hA5); exp_gid_q.push_back(0);
        wait_idle(600);

        // All three requesters valid: order 0,1,2,0.
        apply_reset();
        #3;
        rq0.push_back(8'h11); rq0.push_back(8'h44); rq1.push_back(8'h22); rq2.push_back(8'h33);
        exp_byte_q.push_back(8'h11); exp_byte_q.push_back(8'h22);
        exp_byte_q.push_back(8'h33); exp_byte_q.push_back(8'h44);
        exp_gid_q.push_back(0); exp_gid_q.push_back(1); exp_gid_q.push_back(2); exp_gid_q.push_back(0);
        wait_idle(2000);

        // Baud select change mid-frame is deferred to IDLE.
        @(negedge clock); #3;
        rq1.push_back(8'h5A); exp_byte_q.push_back(8'h5A); exp_gid_q.push_back(1);
        n = 0;
        while (!busy_a && n < 50) begin @(negedge clock); n++; end
        chk("busy_rise", busy_a, 1'b1);
        bsel_in = 3'b100;
        repeat (40) @(negedge clock);
        chk("bsel_frozen_midframe", bsel_out_a, 3'b001);
        n = 0;
        while (busy_a && n < 300) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        chk("bsel_applied_idle", bsel_out_a, 3'b100);
        bsel_in = 3'b011;
        repeat (3) @(negedge clock);
        chk("bsel_illegal_ignored", bsel_out_a, 3'b100);
        bsel_in = 3'b010;
        repeat (2) @(negedge clock);
        chk("bsel_57600", bsel_out_a, 3'b010);
        wait_idle(100);

        // Reset during data bit 3 of 0xC3 (bit 3 is 0).
        apply_reset();
        #3;
        rq1.push_back(8'hC3); exp_gid_q.push_back(1);
        n = 0;
        while (tx_a !== 1'b0 && n < 100) begin @(negedge clock); n++; end
        repeat (16 + 3*16 + 8) @(negedge clock);
        chk("tx_bit3_before_reset", tx_a, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", tx_a, 1'b1);
        chk("async_reset_busy", busy_a, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #3;
        rq0.push_back(8'h3C); rq1.push_back(8'hD4);
        exp_byte_q.push_back(8'h3C); exp_byte_q.push_back(8'hD4);
        exp_gid_q.push_back(0); exp_gid_q.push_back(1);
        wait_idle(1000);

        // Grant coincident with a tick: start bit waits a full tick period.
        n = 0;
        while (tcnt != 4'd14 && n < 20) begin @(negedge clock); n++; end
        #4;
        rq2.push_back(8'h96); exp_byte_q.push_back(8'h96); exp_gid_q.push_back(2);
        n = 0;
        while (!busy_a && n < 20) begin @(negedge clock); n++; end
        c = 0;
        while (tx_a !== 1'b0 && c < 40) begin @(negedge clock); c++; end
        chk("coincident_tick_align", c, 16);
        wait_idle(400);

        // Two-requester, two-stop-bit instance sending 0xFF.
        @(negedge clock);
        req_data_b[7:0] = 8'hFF;
        req_valid_b = 2'b01;
        #1;
        n = 0;
        while (req_ready_b !== 2'b01 && n < 20) begin @(negedge clock); #1; n++; end
        chk("b_ready", req_ready_b, 2'b01);
        @(negedge clock);
        req_valid_b = 2'b00;
        chk("b_grant_id", gid_b, 1'b0);
        n = 0;
        while (tx_b !== 1'b0 && n < 40) begin @(negedge clock); n++; end
        c = 0; hi = 0;
        while (busy_b && c < 400) begin
            @(negedge clock);
            c++;
            if (busy_b && tx_b) hi++;
        end
        chk("b_frame_len", c, 176);
        chk("b_high_cycles", hi, 160);
        chk("b_tx_idle", tx_b, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
